disk_spin_decoder: RTL and testbench

- Receive-side counterpart of the disk-spin seven-segment animator.
- Watches the 8-bit segment bus the animator drives and recovers the lit outer-segment position, spin direction and revolution count.
- Flags illegal frames or illegal steps.
- Sits beside the animator top as a self-check monitor, or on a second board as a decoder of a captured segment bus.

---
 rtl/disk_spin_decoder.sv | 167 ++++++++++++++++
 tb/tb_disk_spin_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_spin_decoder.sv
// Decodes a seven-segment disk-spin animation into position, direction and revolution count.
// Optional stall detection in TRACK is enabled by defining SPIN_STALL_EN.
module disk_spin_decoder #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned REV_W        = 8,
  parameter int unsigned STALL_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [7:0]       SSeg,
  input  logic             Clear,
  output logic [2:0]       Pos,
  output logic             PosValid,
  output logic             Dir,
  output logic             Spinning,
  output logic [REV_W-1:0] RevCount,
  output logic             Error
);

  typedef enum logic [1:0] {StIdle, StSync, StTrack, StFault} state_e;

  state_e             state_q, state_d;
  logic [6:0]         s_q, p_q;
  logic [7:0]         seg;
  logic [2:0]         pos_q, pos_d;
  logic               valid_q, valid_d;
  logic               dir_q, dir_d;
  logic [REV_W-1:0]   rev_q, rev_d, rev_inc;
  logic [2:0]         ones, k, next_cw, next_ccw;
  logic               is_blank, is_pos, is_bad, seg_event;
  logic               unused_dp;

`ifdef SPIN_STALL_EN
  localparam int unsigned StallW = $clog2(STALL_CYCLES + 1) > 0 ? $clog2(STALL_CYCLES + 1) : 1;
  logic [StallW-1:0] stall_q, stall_d;
`endif

  assign seg       = ACTIVE_LOW ? ~SSeg : SSeg;
  assign unused_dp = seg[7];

  always_comb begin
    ones = '0;
    k    = '0;
    for (int i = 0; i < 6; i++) begin
      if (s_q[i]) begin
        ones = ones + 3'd1;
        k    = 3'(i);
      end
    end
    is_blank = (s_q == '0);
    is_pos   = (ones == 3'd1) && !s_q[6];
    is_bad   = !is_blank && !is_pos;
  end

  assign seg_event = (s_q != p_q);
  assign next_cw   = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
  assign next_ccw  = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
  assign rev_inc   = (rev_q == '1) ? rev_q : rev_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    rev_d   = rev_q;
`ifdef SPIN_STALL_EN
    stall_d = '0;
`endif
    if (Clear) begin
      state_d = StIdle;
      rev_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_pos) begin
            state_d = StSync;
            pos_d   = k;
            valid_d = 1'b1;
          end else if (is_bad) begin
            state_d = StFault;
          end
        end
        StSync: begin
          if (seg_event) begin
            if (is_blank) begin
              state_d = StIdle;
              valid_d = 1'b0;
            end else if (is_pos && k == next_cw) begin
              state_d = StTrack;
              pos_d   = k;
              dir_d   = 1'b1;
            end else if (is_pos && k == next_ccw) begin
              state_d = StTrack;
              pos_d   = k;
              dir_d   = 1'b0;
            end else begin
              state_d = StFault;
            end
          end
        end
        StTrack: begin
          if (seg_event) begin
            if (is_blank) begin
              state_d = StIdle;
              valid_d = 1'b0;
            end else if (is_pos && k == next_cw) begin
              // A revolution is credited on the step into a, judged by the step's own direction.
              pos_d = k;
              dir_d = 1'b1;
              if (pos_q == 3'd5) rev_d = rev_inc;
            end else if (is_pos && k == next_ccw) begin
              pos_d = k;
              dir_d = 1'b0;
              if (pos_q == 3'd1) rev_d = rev_inc;
            end else if (!(is_pos && k == pos_q)) begin
              state_d = StFault;
            end
          end
`ifdef SPIN_STALL_EN
          else if (stall_q == StallW'(STALL_CYCLES - 1)) begin
            state_d = StSync;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
        end
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      s_q     <= '0;
      p_q     <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      rev_q   <= '0;
`ifdef SPIN_STALL_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= seg[6:0];
      p_q     <= s_q;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      rev_q   <= rev_d;
`ifdef SPIN_STALL_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign Pos      = pos_q;
  assign PosValid = valid_q;
  assign Dir      = dir_q;
  assign Spinning = (state_q == StTrack);
  assign Error    = (state_q == StFault);
  assign RevCount = rev_q;

endmodule

// File: tb/tb_disk_spin_decoder.sv
// Directed self-checking bench for disk_spin_decoder (active-low segments, 8-bit revolution count).
module tb_disk_spin_decoder;

  logic       Clk;
  logic       nReset;
  logic [7:0] SSeg;
  logic       Clear;
  logic [2:0] Pos;
  logic       PosValid;
  logic       Dir;
  logic       Spinning;
  logic [7:0] RevCount;
  logic       Error;

  int n_cmp  = 0;
  int n_fail = 0;

  disk_spin_decoder #(
    .ACTIVE_LOW  (1'b1),
    .REV_W       (8),
    .STALL_CYCLES(16)
  ) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .SSeg    (SSeg),
    .Clear   (Clear),
    .Pos     (Pos),
    .PosValid(PosValid),
    .Dir     (Dir),
    .Spinning(Spinning),
    .RevCount(RevCount),
    .Error   (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Active-low frame lighting only outer segment k.
  function automatic logic [7:0] seg_of(input int k);
    logic [7:0] v;
    v = 8'h01 << k;
    return ~v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic blank_and_clear();
    SSeg  = 8'hFF;
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Clear  = 1'b0;
    SSeg   = 8'hFE;
    step(3);
    n_cmp++;
    if ({Pos, PosValid, Dir, Spinning, RevCount, Error} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero",
               {Pos, PosValid, Dir, Spinning, RevCount, Error});
    end
    SSeg = 8'hFF;
    step(1);
    nReset = 1'b1;
    step(4);
    n_cmp++;
    if (PosValid !== 1'b0 || Spinning !== 1'b0 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: PosValid=%b Spinning=%b Error=%b want 0 0 0",
               PosValid, Spinning, Error);
    end
  endtask

  task automatic test_cw();
    for (int i = 0; i < 7; i++) begin
      SSeg = seg_of(i % 6);
      if (i == 0) begin
        step(1);
        n_cmp++;
        if (PosValid !== 1'b0) begin
          n_fail++;
          $display("FAIL cw_latency1: PosValid=%b want 0 after one edge", PosValid);
        end
        step(1);
        n_cmp++;
        if (PosValid !== 1'b1) begin
          n_fail++;
          $display("FAIL cw_latency2: PosValid=%b want 1 after two edges", PosValid);
        end
        step(2);
      end else begin
        step(4);
      end
      n_cmp++;
      if (Pos !== 3'(i % 6) || PosValid !== 1'b1) begin
        n_fail++;
        $display("FAIL cw_pos[%0d]: Pos=%0d PosValid=%b want %0d 1", i, Pos, PosValid, i % 6);
      end
      n_cmp++;
      if (Spinning !== (i > 0) || (i > 0 && Dir !== 1'b1)) begin
        n_fail++;
        $display("FAIL cw_spin[%0d]: Spinning=%b Dir=%b want %b 1", i, Spinning, Dir, i > 0);
      end
    end
    n_cmp++;
    if (RevCount !== 8'd1) begin
      n_fail++;
      $display("FAIL cw_rev: RevCount=%0d want 1", RevCount);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    nReset = 1'b0;
    #2;
    n_cmp++;
    if (Spinning !== 1'b0 || RevCount !== 8'd0 || PosValid !== 1'b0 || Pos !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: Spinning=%b RevCount=%0d PosValid=%b Pos=%0d want 0 0 0 0",
               Spinning, RevCount, PosValid, Pos);
    end
    SSeg = 8'hFF;
    step(2);
    nReset = 1'b1;
    step(3);
  endtask

  task automatic test_ccw_reverse();
    for (int i = 0; i < 7; i++) begin
      SSeg = seg_of((6 - i) % 6);
      step(4);
      n_cmp++;
      if (Pos !== 3'((6 - i) % 6) || Spinning !== (i > 0) || (i > 0 && Dir !== 1'b0)) begin
        n_fail++;
        $display("FAIL ccw[%0d]: Pos=%0d Spinning=%b Dir=%b want %0d %b 0",
                 i, Pos, Spinning, Dir, (6 - i) % 6, i > 0);
      end
    end
    n_cmp++;
    if (RevCount !== 8'd1) begin
      n_fail++;
      $display("FAIL ccw_rev: RevCount=%0d want 1", RevCount);
    end
    SSeg = 8'hFD;
    step(4);
    n_cmp++;
    if (Dir !== 1'b1 || Spinning !== 1'b1 || Pos !== 3'd1 || RevCount !== 8'd1) begin
      n_fail++;
      $display("FAIL reverse: Dir=%b Spinning=%b Pos=%0d RevCount=%0d want 1 1 1 1",
               Dir, Spinning, Pos, RevCount);
    end
    blank_and_clear();
  endtask

  task automatic test_skip_fault();
    SSeg = 8'hFE;
    step(4);
    SSeg = 8'hFD;
    step(4);
    SSeg = 8'hF7;
    step(1);
    n_cmp++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_early: Error=%b want 0 one edge after skip", Error);
    end
    step(1);
    n_cmp++;
    if (Error !== 1'b1 || Spinning !== 1'b0 || Pos !== 3'd1 || PosValid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_fault: Error=%b Spinning=%b Pos=%0d PosValid=%b want 1 0 1 1",
               Error, Spinning, Pos, PosValid);
    end
    step(10);
    n_cmp++;
    if (Error !== 1'b1 || Pos !== 3'd1) begin
      n_fail++;
      $display("FAIL skip_sticky: Error=%b Pos=%0d want 1 1", Error, Pos);
    end
    SSeg  = 8'hFF;
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    n_cmp++;
    if (Error !== 1'b0 || RevCount !== 8'd0 || PosValid !== 1'b0 || Spinning !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_clear: Error=%b RevCount=%0d PosValid=%b Spinning=%b want 0 0 0 0",
               Error, RevCount, PosValid, Spinning);
    end
    step(3);
  endtask

  task automatic test_bad_frames();
    SSeg = 8'hFC;
    step(3);
    n_cmp++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_ab: Error=%b want 1", Error);
    end
    blank_and_clear();
    SSeg = 8'hBF;
    step(3);
    n_cmp++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_g: Error=%b want 1", Error);
    end
    blank_and_clear();
    SSeg = 8'h7E;
    step(3);
    n_cmp++;
    if (Error !== 1'b0 || PosValid !== 1'b1 || Pos !== 3'd0) begin
      n_fail++;
      $display("FAIL dp_ignored: Error=%b PosValid=%b Pos=%0d want 0 1 0", Error, PosValid, Pos);
    end
    blank_and_clear();
  endtask

  task automatic test_stall();
    logic exp_spin;
`ifdef SPIN_STALL_EN
    exp_spin = 1'b0;
`else
    exp_spin = 1'b1;
`endif
    SSeg = 8'hFE;
    step(4);
    SSeg = 8'hFD;
    step(4);
    step(30);
    n_cmp++;
    if (Spinning !== exp_spin || Pos !== 3'd1 || PosValid !== 1'b1 || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: Spinning=%b Pos=%0d PosValid=%b Error=%b want %b 1 1 0",
               Spinning, Pos, PosValid, Error, exp_spin);
    end
    SSeg = 8'hFB;
    step(4);
    n_cmp++;
    if (Spinning !== 1'b1 || Dir !== 1'b1 || Pos !== 3'd2) begin
      n_fail++;
      $display("FAIL stall_resume: Spinning=%b Dir=%b Pos=%0d want 1 1 2", Spinning, Dir, Pos);
    end
    blank_and_clear();
  endtask

  initial begin
    test_reset();
    test_cw();
    test_reset_mid();
    test_ccw_reverse();
    test_skip_fault();
    test_bad_frames();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
